// File: rtl/cic3_decim_ctrl.sv
// Sequencer and comb back-end for a free-running 3rd-order CIC integrator chain:
// integrator clear/enable, decimation strobe, three comb stages and a valid/ready output.
module cic3_decim_ctrl #(
  parameter int DMAX_LOG2      = 8,
  parameter int NUMBITS        = 3*DMAX_LOG2+1,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         dec_sel,
  input  logic [NUMBITS-1:0] acc3_in,
  output logic               acc_clear,
  output logic               acc_en,
  output logic [NUMBITS-1:0] sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               busy
);

  localparam int SCW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_dsel;
  logic [DMAX_LOG2-1:0] r_dcnt;
  logic [DMAX_LOG2-1:0] w_dlast;
  logic [SCW-1:0]       r_scnt;
  logic [NUMBITS-1:0]   r_x_d;
  logic [NUMBITS-1:0]   r_c1_d;
  logic [NUMBITS-1:0]   r_c2_d;
  logic [NUMBITS-1:0]   w_c1;
  logic [NUMBITS-1:0]   w_c2;
  logic [NUMBITS-1:0]   w_c3;
  logic [NUMBITS-1:0]   r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_acc_clear;
  logic                 r_acc_en;
  logic                 r_busy;
  logic                 w_active;
  logic                 w_strobe;
  logic                 w_settle_last;
  logic                 w_go;
  logic                 w_abort;
  logic                 w_emit;

  // Decimation ratio is 2^(DMAX_LOG2-3+sel); the counter's terminal value is ratio-1.
  assign w_dlast       = {DMAX_LOG2{1'b1}} >> (2'd3 - r_dsel);
  assign w_active      = (r_state == ST_SETTLE) || (r_state == ST_RUN);
  assign w_strobe      = w_active && (r_dcnt == w_dlast);
  assign w_settle_last = (r_scnt == SCW'(SETTLE_SAMPLES - 1));
  assign w_go          = (r_state == ST_IDLE) && start && !stop;
  assign w_abort       = w_active && stop;
  assign w_emit        = (r_state == ST_RUN) && w_strobe && !stop;

  assign w_c1 = acc3_in - r_x_d;
  assign w_c2 = w_c1 - r_c1_d;
  assign w_c3 = w_c2 - r_c2_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; stop beats start in IDLE and aborts SETTLE/RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_strobe && w_settle_last) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Integrator controls and busy are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_clear <= 1'b0;
      r_acc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_dsel      <= 2'd0;
    end else begin
      r_acc_clear <= (w_state_nxt == ST_CLEAR);
      r_acc_en    <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_RUN);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_go) begin
        r_dsel <= dec_sel;
      end
    end
  end

  // Decimation/settle counters and comb history; history advances on every strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dcnt <= {DMAX_LOG2{1'b0}};
      r_scnt <= {SCW{1'b0}};
      r_x_d  <= {NUMBITS{1'b0}};
      r_c1_d <= {NUMBITS{1'b0}};
      r_c2_d <= {NUMBITS{1'b0}};
    end else if (r_state == ST_CLEAR) begin
      r_dcnt <= {DMAX_LOG2{1'b0}};
      r_scnt <= {SCW{1'b0}};
      r_x_d  <= {NUMBITS{1'b0}};
      r_c1_d <= {NUMBITS{1'b0}};
      r_c2_d <= {NUMBITS{1'b0}};
    end else if (w_strobe) begin
      r_dcnt <= {DMAX_LOG2{1'b0}};
      r_x_d  <= acc3_in;
      r_c1_d <= w_c1;
      r_c2_d <= w_c2;
      if (r_state == ST_SETTLE) begin
        r_scnt <= r_scnt + SCW'(1);
      end
    end else if (w_active) begin
      r_dcnt <= r_dcnt + DMAX_LOG2'(1);
    end
  end

  // Output handshake: a result arriving while an untaken one is held is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= {NUMBITS{1'b0}};
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_go) begin
      r_overrun <= 1'b0;
    end else if ((r_state == ST_CLEAR) || w_abort) begin
      r_valid <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || sample_ready) begin
        r_data  <= w_c3;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign acc_clear    = r_acc_clear;
  assign acc_en       = r_acc_en;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign busy         = r_busy;

endmodule

// File: tb/tb_cic3_decim_ctrl.sv
// Directed bench for cic3_decim_ctrl: integrator model feeds the DUT, a scoreboard
// queue holds expected samples and a forked monitor pops them on each transfer.
module tb_cic3_decim_ctrl;

  localparam int NB = 25;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [1:0]    dec_sel;
  logic [NB-1:0] a1, a2, a3;
  logic          acc_clear;
  logic          acc_en;
  logic [NB-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          busy;
  logic          tb_in;

  int            total = 0;
  int            bad = 0;
  int            exp_gap = 0;
  logic [NB-1:0] q[$];

  cic3_decim_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .dec_sel      (dec_sel),
    .acc3_in      (a3),
    .acc_clear    (acc_clear),
    .acc_en       (acc_en),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integrator chain model driven by the DUT's clear/enable.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= '0; a2 <= '0; a3 <= '0;
    end else if (acc_clear) begin
      a1 <= '0; a2 <= '0; a3 <= '0;
    end else if (acc_en) begin
      a1 <= a1 + {{(NB-1){1'b0}}, tb_in};
      a2 <= a2 + a1;
      a3 <= a3 + a2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int cyc = 0;
    int last = 0;
    bit have = 1'b0;
    logic [NB-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n || !busy) begin
        have = 1'b0;
      end else if (sample_valid && sample_ready) begin
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL sb_unexpected observed=%0d expected=no sample", sample_data);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          total++;
          assert (sample_data === e) else begin
            bad++;
            $error("FAIL sb_data observed=%0d expected=%0d", sample_data, e);
          end
        end
        if (have && exp_gap != 0) begin
          total++;
          assert ((cyc - last) === exp_gap) else begin
            bad++;
            $error("FAIL sb_gap observed=%0d expected=%0d", cyc - last, exp_gap);
          end
        end
        have = 1'b1;
        last = cyc;
      end
    end
  endtask

  task automatic run_start(input logic [1:0] sel, input int d);
    int n;
    dec_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk("clear_pulse_hi", acc_clear, 1);
    chk("busy_after_start", busy, 1);
    chk("overrun_cleared", overrun, 0);
    tick();
    n = 2;
    chk("clear_pulse_lo", acc_clear, 0);
    chk("acc_en_on", acc_en, 1);
    while (!sample_valid && n < 4*d + 50) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 4*d + 2);
  endtask

  task automatic push_n(input int n, input logic [NB-1:0] v);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk("sb_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_acc_en", acc_en, 0);
    chk("stop_valid", sample_valid, 0);
  endtask

  initial begin
    logic [NB-1:0] first;
    bit stable, seen_v, seen_b;
    fork
      monitor();
    join_none

    reset_n = 1'b1; start = 1'b0; stop = 1'b0; dec_sel = 2'd0;
    sample_ready = 1'b1; tb_in = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_clear", acc_clear, 0);
    tick();

    // DC gain, D=32
    tb_in = 1'b1; exp_gap = 32;
    push_n(3, 25'd32768);
    run_start(2'd0, 32);
    drain(500);
    do_stop();

    // DC gain, D=256, then zero input
    exp_gap = 256;
    push_n(3, 25'd16777216);
    run_start(2'd3, 256);
    drain(2000);
    do_stop();
    tb_in = 1'b0;
    push_n(3, 25'd0);
    run_start(2'd3, 256);
    drain(2000);
    do_stop();

    // Backpressure: hold first sample, drop two, then resume
    tb_in = 1'b1; exp_gap = 0; sample_ready = 1'b0;
    push_n(3, 25'd32768);
    run_start(2'd0, 32);
    first = sample_data;
    stable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!sample_valid || sample_data !== first) stable = 1'b0;
    end
    chk("bp_held_stable", stable, 1);
    chk("bp_overrun_set", overrun, 1);
    sample_ready = 1'b1;
    drain(300);
    chk("bp_overrun_sticky", overrun, 1);
    do_stop();
    chk("bp_overrun_idle", overrun, 1);

    // Stop during SETTLE: no output afterwards
    exp_gap = 32;
    dec_sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_overrun_clr", overrun, 0);
    repeat (50) tick();
    do_stop();
    seen_v = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sample_valid) seen_v = 1'b1;
    end
    chk("settle_stop_no_out", seen_v, 0);

    // Restart at D=64; dec_sel changes and a stray start are ignored
    exp_gap = 64;
    push_n(4, 25'd262144);
    run_start(2'd1, 64);
    dec_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_no_clear", acc_clear, 0);
    chk("busy_start_busy", busy, 1);
    dec_sel = 2'd3;
    drain(1000);
    do_stop();

    // Transfer coincident with a new result
    exp_gap = 0; sample_ready = 1'b0;
    push_n(2, 25'd32768);
    run_start(2'd0, 32);
    repeat (31) tick();
    chk("coin_held", sample_valid, 1);
    sample_ready = 1'b1;
    tick();
    chk("coin_valid_stays", sample_valid, 1);
    chk("coin_no_overrun", overrun, 0);
    drain(100);
    do_stop();

    // Reset mid-RUN
    exp_gap = 32;
    push_n(1, 25'd32768);
    run_start(2'd0, 32);
    drain(100);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_acc_en", acc_en, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_data", sample_data, 0);
    chk("arst_overrun", overrun, 0);
    tick();
    tick();
    reset_n = 1'b1;
    seen_v = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sample_valid) seen_v = 1'b1;
      if (busy || acc_en || acc_clear) seen_b = 1'b1;
    end
    chk("post_rst_no_valid", seen_v, 0);
    chk("post_rst_idle", seen_b, 0);
    chk("sb_final_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
